// File: rtl/cache_2way_wb.sv
// cache_2way_wb: two-way set-associative, write-back, write-allocate cache
// with per-set LRU and a blocking miss engine (one-word lines).
// Optional build macro CACHE_STATS_EN adds saturating hit/miss counters.
module cache_2way_wb #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int INDEX_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_hit,
  output logic              mem_req,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
`endif
);

  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int SETS  = 1 << INDEX_W;

  typedef enum logic [1:0] {IDLE = 2'd0, WBACK = 2'd1, FILL = 2'd2, RESP = 2'd3} state_e;

  state_e              state_q;
  logic [1:0]          valid_q [SETS];
  logic [1:0]          dirty_q [SETS];
  logic [SETS-1:0]     lru_q;
  logic [TAG_W-1:0]    tag_q   [SETS][2];
  logic [DATA_W-1:0]   data_q  [SETS][2];

  logic [INDEX_W-1:0]  lat_idx_q;
  logic [TAG_W-1:0]    lat_tag_q;
  logic                lat_write_q;
  logic [DATA_W-1:0]   lat_wdata_q;
  logic                victim_q;

  logic                req_ready_q, rsp_valid_q, rsp_hit_q;
  logic [DATA_W-1:0]   rsp_rdata_q, mem_wdata_q;
  logic                mem_req_q, mem_write_q;
  logic [ADDR_W-1:0]   mem_addr_q;

  logic [INDEX_W-1:0]  req_idx_s;
  logic [TAG_W-1:0]    req_tag_s;
  logic                hit0_s, hit1_s, hit_s, hit_way_s, victim_s, accept_s, fill_done_s;
  logic                arr_we_s, arr_way_s;
  logic [INDEX_W-1:0]  arr_idx_s;
  logic [TAG_W-1:0]    arr_tag_s;
  logic [DATA_W-1:0]   arr_data_s;

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_hit   = rsp_hit_q;
  assign mem_req   = mem_req_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  assign req_idx_s   = req_addr[INDEX_W-1:0];
  assign req_tag_s   = req_addr[ADDR_W-1:INDEX_W];
  assign hit0_s      = valid_q[req_idx_s][0] && (tag_q[req_idx_s][0] == req_tag_s);
  assign hit1_s      = valid_q[req_idx_s][1] && (tag_q[req_idx_s][1] == req_tag_s);
  assign hit_s       = hit0_s || hit1_s;
  assign hit_way_s   = hit1_s;
  assign accept_s    = (state_q == IDLE) && req_valid && req_ready_q;
  assign fill_done_s = (state_q == FILL) && mem_req_q && mem_ack;

  // Victim choice: first invalid way (way0 first), otherwise the LRU way.
  always_comb begin
    victim_s = 1'b0;
    if (!valid_q[req_idx_s][0]) begin
      victim_s = 1'b0;
    end else if (!valid_q[req_idx_s][1]) begin
      victim_s = 1'b1;
    end else begin
      victim_s = lru_q[req_idx_s];
    end
  end

  // Tag/data array write port: store hits and refill completion.
  always_comb begin
    arr_we_s   = 1'b0;
    arr_way_s  = 1'b0;
    arr_idx_s  = req_idx_s;
    arr_tag_s  = req_tag_s;
    arr_data_s = req_wdata;
    if (accept_s && hit_s && req_write) begin
      arr_we_s  = 1'b1;
      arr_way_s = hit_way_s;
    end else if (fill_done_s) begin
      arr_we_s   = 1'b1;
      arr_way_s  = victim_q;
      arr_idx_s  = lat_idx_q;
      arr_tag_s  = lat_tag_q;
      arr_data_s = lat_write_q ? lat_wdata_q : mem_rdata;
    end else begin
      arr_we_s = 1'b0;
    end
  end

  // Tag/data storage; contents are meaningful only where valid is set, so no reset.
  always_ff @(posedge clk) begin
    if (arr_we_s) begin
      tag_q[arr_idx_s][arr_way_s]  <= arr_tag_s;
      data_q[arr_idx_s][arr_way_s] <= arr_data_s;
    end
  end

  // Miss/response FSM with registered outputs and valid/dirty/LRU state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= 2'b00;
        dirty_q[s] <= 2'b00;
      end
      lru_q       <= '0;
      lat_idx_q   <= '0;
      lat_tag_q   <= '0;
      lat_write_q <= 1'b0;
      lat_wdata_q <= '0;
      victim_q    <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            lat_idx_q   <= req_idx_s;
            lat_tag_q   <= req_tag_s;
            lat_write_q <= req_write;
            lat_wdata_q <= req_wdata;
            req_ready_q <= 1'b0;
            if (hit_s) begin
              rsp_valid_q          <= 1'b1;
              rsp_hit_q            <= 1'b1;
              rsp_rdata_q          <= req_write ? '0 : data_q[req_idx_s][hit_way_s];
              lru_q[req_idx_s]     <= ~hit_way_s;
              if (req_write) begin
                dirty_q[req_idx_s][hit_way_s] <= 1'b1;
              end
              state_q              <= RESP;
            end else begin
              victim_q  <= victim_s;
              mem_req_q <= 1'b1;
              if (valid_q[req_idx_s][victim_s] && dirty_q[req_idx_s][victim_s]) begin
                mem_write_q <= 1'b1;
                mem_addr_q  <= {tag_q[req_idx_s][victim_s], req_idx_s};
                mem_wdata_q <= data_q[req_idx_s][victim_s];
                state_q     <= WBACK;
              end else begin
                mem_write_q <= 1'b0;
                mem_addr_q  <= req_addr;
                mem_wdata_q <= '0;
                state_q     <= FILL;
              end
            end
          end else begin
            state_q <= IDLE;
          end
        end
        WBACK: begin
          if (mem_req_q && mem_ack) begin
            mem_write_q <= 1'b0;
            mem_addr_q  <= {lat_tag_q, lat_idx_q};
            mem_wdata_q <= '0;
            state_q     <= FILL;
          end else begin
            state_q <= WBACK;
          end
        end
        FILL: begin
          if (fill_done_s) begin
            valid_q[lat_idx_q][victim_q] <= 1'b1;
            dirty_q[lat_idx_q][victim_q] <= lat_write_q;
            lru_q[lat_idx_q]             <= ~victim_q;
            mem_req_q                    <= 1'b0;
            mem_addr_q                   <= '0;
            rsp_valid_q                  <= 1'b1;
            rsp_hit_q                    <= 1'b0;
            rsp_rdata_q                  <= lat_write_q ? '0 : mem_rdata;
            state_q                      <= RESP;
          end else begin
            state_q <= FILL;
          end
        end
        RESP: begin
          rsp_valid_q <= 1'b0;
          rsp_hit_q   <= 1'b0;
          rsp_rdata_q <= '0;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          mem_req_q   <= 1'b0;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

  // Saturating hit/miss counters, bumped once per completed request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= 16'h0000;
      miss_cnt_q <= 16'h0000;
    end else if (state_q == RESP) begin
      if (rsp_hit_q) begin
        if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'h0001;
      end else begin
        if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_2way_wb.sv
// Directed testbench for cache_2way_wb with a behavioural memory responder.
module tb_cache_2way_wb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [7:0]  req_addr = 8'h00;
  logic [15:0] req_wdata = 16'h0000;
  logic        rsp_valid, rsp_hit;
  logic [15:0] rsp_rdata;
  logic        mem_req, mem_write, mem_ack;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  int n_checks = 0;
  int n_fail = 0;

  // memory model state
  logic [15:0] mem [256];
  int          ack_delay = 3;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          unstable = 0;
  logic [7:0]  last_wa = 8'h00;
  logic [15:0] last_wd = 16'h0000;

  cache_2way_wb #(.ADDR_W(8), .DATA_W(16), .INDEX_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_hit(rsp_hit),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef CACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory responder: acks on the ack_delay-th cycle of a held request.
  initial begin : mem_model
    int          cnt;
    logic [7:0]  a0;
    logic        w0;
    logic [15:0] d0;
    cnt = 0; a0 = 8'h00; w0 = 1'b0; d0 = 16'h0000;
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    mem[8'h13] = 16'hBEEF;
    mem_ack = 1'b0;
    mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_ack = 1'b0;
        cnt = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
        mem_rdata = 16'h0000;
        cnt = 0;
      end else if (mem_req) begin
        if (cnt == 0) begin
          a0 = mem_addr; w0 = mem_write; d0 = mem_wdata;
        end else if (mem_addr !== a0 || mem_write !== w0 || mem_wdata !== d0) begin
          unstable++;
        end
        cnt++;
        if (cnt >= ack_delay) begin
          mem_ack = 1'b1;
          if (mem_write) begin
            mem[mem_addr] = mem_wdata;
            wr_cnt++;
            last_wa = mem_addr;
            last_wd = mem_wdata;
          end else begin
            mem_rdata = mem[mem_addr];
            rd_cnt++;
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Issue one request and wait (bounded) for its response pulse.
  task automatic do_req(input logic wr, input logic [7:0] addr, input logic [15:0] wd,
                        output logic [15:0] rd, output logic hit, output int lat,
                        output logic rdy1);
    int g;
    logic seen;
    g = 0; seen = 1'b0; lat = 0; rd = 16'h0000; hit = 1'b0; rdy1 = 1'b1;
    @(negedge clk);
    while (!req_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    while (!seen && lat < 300) begin
      @(negedge clk);
      lat++;
      if (lat == 1) rdy1 = req_ready;
      if (rsp_valid) begin
        seen = 1'b1;
        rd = rsp_rdata;
        hit = rsp_hit;
      end
    end
    if (!seen) check_eq("rsp_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check_eq("rsp_one_cycle", 32'(rsp_valid), 32'd0);
  endtask

  task automatic load_chk(input string tag, input logic [7:0] addr,
                          input logic [15:0] exp_d, input logic exp_hit);
    logic [15:0] rd;
    logic hit, r1;
    int lat;
    do_req(1'b0, addr, 16'h0000, rd, hit, lat, r1);
    check_eq({tag, "_data"}, 32'(rd), 32'(exp_d));
    check_eq({tag, "_hit"}, 32'(hit), 32'(exp_hit));
  endtask

  task automatic store_chk(input string tag, input logic [7:0] addr,
                           input logic [15:0] wd, input logic exp_hit);
    logic [15:0] rd;
    logic hit, r1;
    int lat;
    do_req(1'b1, addr, wd, rd, hit, lat, r1);
    check_eq({tag, "_rdata0"}, 32'(rd), 32'd0);
    check_eq({tag, "_hit"}, 32'(hit), 32'(exp_hit));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  initial begin : main
    logic [15:0] rd;
    logic hit, r1;
    int lat;

    repeat (3) @(negedge clk);
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_hit", 32'(rsp_hit), 32'd0);
    check_eq("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check_eq("rst_mem_write", 32'(mem_write), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_mem_wdata", 32'(mem_wdata), 32'd0);

    // cold miss then hit on 0x13
    load_chk("ld13_miss", 8'h13, 16'hBEEF, 1'b0);
    do_req(1'b0, 8'h13, 16'h0000, rd, hit, lat, r1);
    check_eq("ld13_hit_data", 32'(rd), 32'hBEEF);
    check_eq("ld13_hit_flag", 32'(hit), 32'd1);
    check_eq("hit_latency", 32'(lat), 32'd1);
    check_eq("hit_ready_low", 32'(r1), 32'd0);

    // two stores fill both ways of set 1
    store_chk("st01", 8'h01, 16'hAAAA, 1'b0);
    store_chk("st05", 8'h05, 16'hAAAA, 1'b0);
    check_eq("no_wb_yet", 32'(wr_cnt), 32'd0);
    load_chk("ld01", 8'h01, 16'hAAAA, 1'b1);
    load_chk("ld05", 8'h05, 16'hAAAA, 1'b1);

    // 0x01 is now LRU and dirty: load 0x09 must write it back first
    load_chk("ld05b", 8'h05, 16'hAAAA, 1'b1);
    load_chk("ld09", 8'h09, 16'h1009, 1'b0);
    check_eq("wb_count", 32'(wr_cnt), 32'd1);
    check_eq("wb_addr", 32'(last_wa), 32'h01);
    check_eq("wb_data", 32'(last_wd), 32'hAAAA);
    load_chk("ld05c", 8'h05, 16'hAAAA, 1'b1);

    // clean victim (0x09) evicted by 0x01, slow memory
    ack_delay = 5;
    do_req(1'b0, 8'h01, 16'h0000, rd, hit, lat, r1);
    check_eq("ld01_refill_data", 32'(rd), 32'hAAAA);
    check_eq("ld01_refill_hit", 32'(hit), 32'd0);
    check_eq("clean_miss_latency", 32'(lat), 32'd6);
    check_eq("clean_no_wb", 32'(wr_cnt), 32'd1);
    check_eq("mem_stable", 32'(unstable), 32'd0);

    // reset while a refill is outstanding
    ack_delay = 100;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h22;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("fill_mem_req", 32'(mem_req), 32'd1);
    check_eq("fill_mem_addr", 32'(mem_addr), 32'h22);
    rst_n = 1'b0;
    #1;
    check_eq("midreset_mem_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ack_delay = 2;
    @(negedge clk);
    check_eq("post_reset_ready", 32'(req_ready), 32'd1);

    // cache emptied; dirty 0x05 was lost, memory still holds old value
    load_chk("pr_ld13", 8'h13, 16'hBEEF, 1'b0);
    load_chk("pr_ld13b", 8'h13, 16'hBEEF, 1'b1);
    load_chk("pr_ld05", 8'h05, 16'h1005, 1'b0);
    load_chk("pr_ld05b", 8'h05, 16'h1005, 1'b1);
    load_chk("pr_ld13c", 8'h13, 16'hBEEF, 1'b1);
`ifdef CACHE_STATS_EN
    check_eq("hit_cnt", 32'(hit_cnt), 32'd3);
    check_eq("miss_cnt", 32'(miss_cnt), 32'd2);
    rst_n = 1'b0;
    #1;
    check_eq("hit_cnt_rst", 32'(hit_cnt), 32'd0);
    check_eq("miss_cnt_rst", 32'(miss_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_2way_wb.md
# cache_2way_wb

Two-way set-associative, write-back, write-allocate cache with true per-set LRU replacement and a blocking miss engine. It sits between the datapath load/store port and a slower memory, and is parametrised in address width, data width and set count. On a miss it evicts dirty victims to memory, refills the line and then completes the request. One-word lines; one outstanding request at a time.

## Interface

Parameters:
- ADDR_W, 8, word address width
- DATA_W, 16, data word width
- INDEX_W, 2, set index width; sets = 2**INDEX_W; tag width = ADDR_W-INDEX_W (INDEX_W < ADDR_W)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  CPU request present
- req_ready  out  1  cache can accept request (high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  word address; index = req_addr[INDEX_W-1:0], tag = upper bits
- req_wdata  in  DATA_W  store data
- rsp_valid  out  1  one-cycle pulse: request complete
- rsp_rdata  out  DATA_W  load data, valid with rsp_valid (0 for stores)
- rsp_hit  out  1  1 if request hit, valid with rsp_valid
- mem_req  out  1  memory transaction active; held until mem_ack
- mem_write  out  1  1 = writeback, 0 = refill read
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  victim data for writeback
- mem_ack  in  1  memory completes transaction this cycle
- mem_rdata  in  DATA_W  refill data, valid when mem_ack and !mem_write

## Operation

- Per set, per way: valid, dirty, tag, data. Per set: lru bit = index of least-recently-used way.
- States: IDLE, WBACK, FILL, RESP.
- IDLE: on req_valid&&req_ready, latch request, compare tags of both valid ways.
  - Hit: load returns way data; store writes data, sets dirty. lru set to other way. Next state RESP with rsp_hit=1.
  - Miss: victim = first invalid way (way0 before way1), else way lru. Victim valid and dirty -> WBACK, else FILL.
- WBACK: mem_req=1, mem_write=1, mem_addr={victim tag, index}, mem_wdata=victim data. On mem_ack -> FILL.
- FILL: mem_req=1, mem_write=0, mem_addr=latched address. On mem_ack: victim way gets valid=1, new tag, data = mem_rdata (load) or req_wdata (store); dirty = store ? 1 : 0; lru points to other way -> RESP with rsp_hit=0, rsp_rdata = mem_rdata for loads.
- RESP: rsp_valid=1 for one cycle -> IDLE.
- Both ways never hold the same valid tag in one set.

## Timing

- Reset (async assert, sync use after deassert): state IDLE; all valid, dirty, lru bits 0; req_ready=1 after reset; rsp_valid, rsp_hit, rsp_rdata, mem_req, mem_write, mem_addr, mem_wdata all 0. Data/tag arrays not reset.
- Hit latency: request accepted at edge N, rsp_valid high in cycle N+1, req_ready low in cycle N+1, high again N+2.
- Clean miss: 1 + refill wait + 1 cycles; dirty miss adds writeback wait.
- mem_req asserts the cycle after entering WBACK/FILL, stays high with stable mem_addr/mem_wdata/mem_write until a cycle with mem_ack; mem_req drops the cycle after ack. mem_ack while mem_req=0 is ignored.
- WBACK->FILL: mem_req may stay high across the boundary; mem_write/mem_addr change the cycle after ack.
- req_valid ignored while req_ready=0; no request is queued.
- Reset mid-miss: transaction abandoned, mem_req drops immediately, cache empties (all invalid); dirty data lost by definition.

## Configuration

- CACHE_STATS_EN defined: adds outputs hit_cnt and miss_cnt (each 16-bit, out), incremented on each RESP cycle by rsp_hit, saturating at 16'hFFFF, cleared by rst_n.
- Undefined: ports and counters absent; other behaviour identical.

## Test plan

- After reset, load 0x13 with memory returning 0xBEEF on ack after 3 cycles -> FILL then rsp_valid, rsp_hit=0, rsp_rdata=0xBEEF; repeat load -> rsp_hit=1, 0xBEEF, rsp_valid one cycle after accept.
- Store 0xAAAA to 0x01, 0x05 (same set, INDEX_W=2) -> both refilled into way0/way1, no writeback; loads return 0xAAAA each with rsp_hit=1.
- Then load 0x05, then load 0x09 -> victim is 0x01's way (LRU): WBACK with mem_addr=0x01, mem_wdata=0xAAAA, then FILL of 0x09; load 0x05 still hits.
- Load miss to clean victim -> no mem_write transaction; mem_addr held stable while mem_ack delayed 5 cycles.
- Assert rst_n low during FILL -> mem_req=0 at once, req_ready=1 after release, previous address now misses.
- With CACHE_STATS_EN: 3 hits, 2 misses -> hit_cnt=3, miss_cnt=2; reset -> both 0.
